// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between a
// loader, the data-memory stage and instruction fetch.
//   Loader has absolute priority; data vs fetch alternate on a 1-bit
//   round-robin pointer when both request. Grants and memory strobes are
//   combinational on the current-cycle requests; read data returns one
//   cycle after a read grant together with that port's rvalid.
// Ports:
//   clk1, rst_n                       clock, async active-low reset
//   ld_* / dm_* / if_*                requester inputs
//   halted                            masks fetch requests
//   *_gnt                             request accepted this cycle
//   *_rvalid, rdata                   read return (one cycle after grant)
//   mem_en/we/addr/wdata, mem_rdata   memory-side interface
//   conflict_cnt                      saturating count of contended cycles
module mem_port_arbiter #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          halted,
    output logic          ld_gnt,
    output logic          dm_gnt,
    output logic          if_gnt,
    output logic          ld_rvalid,
    output logic          dm_rvalid,
    output logic          if_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [CW-1:0] conflict_cnt
);

    logic          r_rr;
    logic          r_ld_rvalid;
    logic          r_dm_rvalid;
    logic          r_if_rvalid;
    logic [DW-1:0] r_rdata;
    logic [CW-1:0] r_cnt;

    logic          w_if_eff;
    logic          w_ld_win;
    logic          w_dm_win;
    logic          w_if_win;
    logic          w_any_rvalid;
    logic          w_dm_if_both;
    logic [1:0]    w_nreq;

    // Effective requests and winner selection
    assign w_if_eff     = if_req & ~halted;
    assign w_dm_if_both = dm_req & w_if_eff;
    assign w_ld_win     = ld_req;
    assign w_dm_win     = ~ld_req & dm_req & (~w_if_eff | ~r_rr);
    assign w_if_win     = ~ld_req & w_if_eff & (~dm_req | r_rr);

    // Grants are held low while reset is asserted
    assign ld_gnt = w_ld_win & rst_n;
    assign dm_gnt = w_dm_win & rst_n;
    assign if_gnt = w_if_win & rst_n;

    // Memory strobe mux; idle cycles drive all-zero
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end else if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    // Round-robin pointer flips only when data and fetch actually competed
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= 1'b0;
        end else if (w_dm_if_both && !ld_req) begin
            r_rr <= ~r_rr;
        end
    end

    // Read return tracking: one cycle after each read grant
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
            r_if_rvalid <= 1'b0;
        end else begin
            r_ld_rvalid <= ld_gnt & ~ld_we;
            r_dm_rvalid <= dm_gnt & ~dm_we;
            r_if_rvalid <= if_gnt;
        end
    end

    assign ld_rvalid    = r_ld_rvalid;
    assign dm_rvalid    = r_dm_rvalid;
    assign if_rvalid    = r_if_rvalid;
    assign w_any_rvalid = r_ld_rvalid | r_dm_rvalid | r_if_rvalid;

    // Capture returning memory data; during the return cycle the incoming
    // word is presented directly so rdata lines up with rvalid, afterwards
    // the captured copy is held.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (w_any_rvalid) begin
            r_rdata <= mem_rdata;
        end
    end

    assign rdata = w_any_rvalid ? mem_rdata : r_rdata;

    // Contention counter: two or more effective requests, saturating
    assign w_nreq = 2'({1'b0, ld_req}) + 2'({1'b0, dm_req}) + 2'({1'b0, w_if_eff});

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((w_nreq >= 2'd2) && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign conflict_cnt = r_cnt;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, default 10, memory word-address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter CW, default 16, contention-counter width.
REQ-004 clk1  input  1  single clock, all state updates on rising edge; the block uses one clock only.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 ld_req/ld_we  input  1/1  loader (program/data preload) request, write enable.
REQ-007 ld_addr/ld_wdata  input  AW/DW  loader address, write data.
REQ-008 dm_req/dm_we/dm_addr/dm_wdata  input  1/1/AW/DW  data-memory (LW/SW stage) request.
REQ-009 if_req/if_addr  input  1/AW  instruction-fetch read request.
REQ-010 halted  input  1  processor HALTED flag; masks fetch requests.
REQ-011 ld_gnt/dm_gnt/if_gnt  output  1 each  request accepted this cycle.
REQ-012 ld_rvalid/dm_rvalid/if_rvalid  output  1 each  read data valid for that port.
REQ-013 rdata  output  DW  registered copy of mem_rdata, shared by all ports.
REQ-014 mem_en/mem_we  output  1/1  single-port synchronous memory strobe, write enable.
REQ-015 mem_addr/mem_wdata  output  AW/DW  memory address, write data.
REQ-016 mem_rdata  input  DW  memory read data, valid one cycle after a read strobe.
REQ-017 conflict_cnt  output  CW  saturating count of contended cycles.

Function
REQ-018 Arbitration combinational on current-cycle requests; at most one gnt high per cycle.
REQ-019 Effective fetch request = if_req AND NOT halted.
REQ-020 Loader has absolute priority; any ld_req wins regardless of other requests.
REQ-021 Data vs fetch (loader idle): round-robin on 1-bit pointer rr; rr=0 favours data, rr=1 favours fetch.
REQ-022 rr toggles only on cycles where data and effective fetch both request and one of them is granted; rr unchanged otherwise.
REQ-023 On grant, mem_en=1, mem_we/mem_addr/mem_wdata driven from winner same cycle; fetch always mem_we=0.
REQ-024 No request granted: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-025 Read grant in cycle N -> that port's rvalid high exactly in cycle N+1, rdata=mem_rdata sampled at end of cycle N+1 registered into rdata in the same cycle it is presented, i.e. rdata valid coincident with rvalid.
REQ-026 Write grant produces no rvalid; rdata holds previous value.
REQ-027 Back-to-back grants allowed every cycle; throughput one access per cycle.
REQ-028 Requester holds req/addr/data stable until gnt; ungranted request is not queued internally.
REQ-029 conflict_cnt increments by 1 each cycle where 2 or more effective requests are high; saturates at all-ones, no wrap.
REQ-030 halted rising while a fetch read is in flight: the in-flight if_rvalid still issues in the following cycle.
REQ-031 Simultaneous ld_req and write-back of an earlier read: rvalid of earlier read unaffected.

Reset
REQ-032 rst_n low asynchronously clears rr=0, all rvalid=0, rdata=0, conflict_cnt=0; gnts and mem_en forced 0 while rst_n low.
REQ-033 Reset mid-read: pending rvalid discarded, not issued after reset release.
REQ-034 First rising edge after rst_n release accepts requests normally.

Verification
REQ-035 Fetch only: if_req=1, if_addr=5, mem_rdata=0x28020001 next cycle -> if_gnt cycle N, if_rvalid and rdata=0x28020001 cycle N+1.
REQ-036 Contention: dm_req and if_req held high 4 cycles from reset -> grants dm, if, dm, if; conflict_cnt=4 (only those cycles contended if each port drops after its grant is re-issued).
REQ-037 Loader priority: ld_req=1 ld_we=1 ld_addr=200 ld_wdata=7 with dm_req, if_req high -> ld_gnt only, mem_we=1, mem_addr=200, mem_wdata=7; rr unchanged.
REQ-038 Halt masking: halted=1, if_req=1 for 10 cycles -> no if_gnt, mem_en=0, conflict_cnt unchanged.
REQ-039 Saturation: CW=4, 20 contended cycles -> conflict_cnt=15 and stays.
REQ-040 Reset mid-operation: dm read granted cycle N, rst_n low during cycle N+1 -> dm_rvalid=0, rdata=0, rr=0.
